// File: rtl/bus_arbiter.sv
// Four-requester round-robin bus arbiter with per-grant ownership timer
// and a one-cycle turnaround slot between owners.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       bus_busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  // TIMEOUT above 256 truncates here; the timer saturates at 255 anyway.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
  localparam bit         TIMER_EN   = (TIMEOUT != 0);

  state_t     state, state_nxt;
  logic [3:0] grant_nxt;
  logic [1:0] id_nxt;
  logic [1:0] last_owner, last_nxt;
  logic [7:0] timer, timer_nxt;
  logic       timeout_nxt;
  logic [1:0] winner, cand;
  logic       found;
  logic       owner_done, owner_drop, expire;

  // Search starts one past the previous owner; the previous owner is tried last.
  always_comb begin
    winner = last_owner;
    found  = 1'b0;
    cand   = last_owner;
    for (int i = 1; i <= 4; i++) begin
      cand = last_owner + 2'(i);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign owner_done = done[grant_id];
  assign owner_drop = ~req[grant_id];
  assign expire     = TIMER_EN && (timer == TIMER_LAST);

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    id_nxt      = grant_id;
    last_nxt    = last_owner;
    timer_nxt   = timer;
    timeout_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = 4'b0001 << winner;
          id_nxt    = winner;
          timer_nxt = 8'd0;
          state_nxt = OWN;
        end
      end
      OWN: begin
        if (timer != 8'hff) timer_nxt = timer + 8'd1;
        if (owner_done || owner_drop || expire) begin
          grant_nxt   = 4'b0000;
          last_nxt    = grant_id;
          state_nxt   = TURN;
          // A normal completion in the expiry cycle wins over the timer.
          timeout_nxt = expire && !owner_done && !owner_drop;
        end
      end
      TURN: begin
        grant_nxt = 4'b0000;
        state_nxt = IDLE;
      end
      default: begin
        grant_nxt = 4'b0000;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 4'b0000;
      grant_id   <= 2'd0;
      bus_busy   <= 1'b0;
      timeout    <= 1'b0;
      timer      <= 8'd0;
      last_owner <= 2'd3;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      grant_id   <= id_nxt;
      bus_busy   <= |grant_nxt;
      timeout    <= timeout_nxt;
      timer      <= timer_nxt;
      last_owner <= last_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a cycle model per instance checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_bus_arbiter;

  localparam int TMO = 16;

  logic       clk;
  logic       reset;
  logic [3:0] req, done, req0, done0;
  logic [3:0] grant, grant0;
  logic [1:0] grant_id, grant_id0;
  logic       bus_busy, bus_busy0, timeout, timeout0;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .grant(grant), .grant_id(grant_id), .bus_busy(bus_busy), .timeout(timeout)
  );

  bus_arbiter #(.TIMEOUT(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .done(done0),
    .grant(grant0), .grant_id(grant_id0), .bus_busy(bus_busy0), .timeout(timeout0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: owner (-1 = none), cycles owned, turnaround cycles left to skip.
  typedef struct {
    int         owner;
    int         age;
    int         gap;
    int         last;
    logic [3:0] grant;
    logic [1:0] id;
    logic       to;
  } mstate_t;

  mstate_t m, m0;

  function automatic mstate_t rst_state();
    mstate_t n;
    n.owner = -1; n.age = 0; n.gap = 0; n.last = 3;
    n.grant = 4'b0000; n.id = 2'd0; n.to = 1'b0;
    return n;
  endfunction

  function automatic mstate_t step(mstate_t s, logic [3:0] r, logic [3:0] d, int tmo);
    mstate_t n = s;
    n.to = 1'b0;
    if (s.owner >= 0) begin
      n.age = s.age + 1;
      if (d[s.owner] || !r[s.owner] || (tmo != 0 && n.age == tmo)) begin
        n.to    = !d[s.owner] && r[s.owner];
        n.last  = s.owner;
        n.owner = -1;
        n.gap   = 1;
        n.grant = 4'b0000;
      end
    end else if (s.gap > 0) begin
      n.gap = s.gap - 1;
    end else if (r != 4'b0000) begin
      for (int i = 1; i <= 4; i++) begin
        int c;
        c = (s.last + i) % 4;
        if (n.owner < 0 && r[c]) begin
          n.owner = c;
          n.id    = 2'(c);
          n.grant = 4'(1 << c);
          n.age   = 0;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m  <= rst_state();
      m0 <= rst_state();
    end else begin
      m  <= step(m, req, done, TMO);
      m0 <= step(m0, req0, done0, 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model grant", 32'(grant), 32'(m.grant));
    check("model grant_id", 32'(grant_id), 32'(m.id));
    check("model bus_busy", 32'(bus_busy), 32'(|m.grant));
    check("model timeout", 32'(timeout), 32'(m.to));
    check("model0 grant", 32'(grant0), 32'(m0.grant));
    check("model0 grant_id", 32'(grant_id0), 32'(m0.id));
    check("model0 bus_busy", 32'(bus_busy0), 32'(|m0.grant));
    check("model0 timeout", 32'(timeout0), 32'(m0.to));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt, zeros;
    logic [3:0] exp;
    bit ok, to_seen;

    reset = 1'b0; req = '0; done = '0; req0 = '0; done0 = '0;
    #1 reset = 1'b1;
    tick(); tick();
    check("reset grant", 32'(grant), 32'h0);
    check("reset grant_id", 32'(grant_id), 32'h0);
    check("reset bus_busy", 32'(bus_busy), 32'h0);
    check("reset timeout", 32'(timeout), 32'h0);
    reset = 1'b0;

    // Two requesters: bit0 first, then bit2 after a two-cycle gap.
    req = 4'b0101;
    tick();
    check("rr first grant", 32'(grant), 32'h1);
    done = 4'b0001;
    tick();
    done = 4'b0000;
    check("after done gap1", 32'(grant), 32'h0);
    tick();
    check("after done gap2", 32'(grant), 32'h0);
    tick();
    check("second grant", 32'(grant), 32'h4);
    check("second grant_id", 32'(grant_id), 32'h2);
    req = 4'b0000;
    tick(); tick(); tick();

    // Non-owner done and other req toggles during ownership are ignored.
    reset_pulse();
    req = 4'b0001;
    tick();
    check("owner0 grant", 32'(grant), 32'h1);
    done = 4'b1000; req = 4'b0101;
    tick();
    check("ignore foreign done", 32'(grant), 32'h1);
    done = 4'b0000; req = 4'b0001;
    tick();
    check("ignore req toggle", 32'(grant), 32'h1);
    req = 4'b0101;
    tick();
    check("ignore req toggle 2", 32'(grant), 32'h1);
    req = 4'b0000;
    tick(); tick(); tick();

    // All four requesting: strict rotation with two idle cycles between owners.
    reset_pulse();
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp = 4'(1 << (n % 4));
      zeros = 0;
      while (grant === 4'b0000 && zeros < 10) begin
        zeros++;
        tick();
      end
      check("rotation grant", 32'(grant), 32'(exp));
      if (n > 0) check("rotation gap", 32'(zeros), 32'd2);
      tick(); tick();
      done = exp;
      tick();
      done = 4'b0000;
    end
    req = 4'b0000;
    tick(); tick(); tick();

    // Timeout: 16 owned cycles, one-cycle pulse, re-grant two cycles later.
    reset_pulse();
    req = 4'b0010;
    tick();
    cnt = 0;
    while (grant === 4'b0010 && cnt < 40) begin
      cnt++;
      tick();
    end
    check("timeout length", 32'(cnt), 32'd16);
    check("timeout pulse", 32'(timeout), 32'h1);
    check("timeout grant clear", 32'(grant), 32'h0);
    tick();
    check("timeout pulse end", 32'(timeout), 32'h0);
    check("timeout gap", 32'(grant), 32'h0);
    tick();
    check("timeout regrant", 32'(grant), 32'h2);
    req = 4'b0000;
    tick(); tick(); tick();

    // Async reset mid-ownership drops the grant at once.
    reset_pulse();
    req = 4'b0100;
    tick();
    check("owner2 grant", 32'(grant), 32'h4);
    #1 reset = 1'b1;
    #1;
    check("async reset grant", 32'(grant), 32'h0);
    check("async reset busy", 32'(bus_busy), 32'h0);
    check("async reset timeout", 32'(timeout), 32'h0);
    tick();
    req = 4'b0110;
    reset = 1'b0;
    tick();
    check("post reset grant", 32'(grant), 32'h2);
    check("post reset grant_id", 32'(grant_id), 32'h1);
    req = 4'b0000;
    tick(); tick(); tick();

    // Timer disabled: ownership never ends, timer saturates.
    reset_pulse();
    req0 = 4'b0001;
    tick();
    ok = 1'b1; to_seen = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (grant0 !== 4'b0001) ok = 1'b0;
      if (timeout0 !== 1'b0) to_seen = 1'b1;
      tick();
    end
    check("no-timeout continuous grant", 32'(ok), 32'h1);
    check("no-timeout pulse absent", 32'(to_seen), 32'h0);
    check("no-timeout timer saturated", 32'(dut0.timer), 32'hff);
    req0 = 4'b0000;
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
